// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, req/ack fetch from instruction memory,
// IF/ID pipeline register with decode stall, one-entry stall buffer and jump/branch redirect.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        jump,
    input  logic        branch_taken,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc4,
    output logic [5:0]  op
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      stateR, stateNext;
    logic        reqR;
    logic [31:0] pcR, pcNext;
    logic [31:0] redirPcR, redirPcNext;
    logic [31:0] bufInstrR, bufInstrNext;
    logic [31:0] bufPc4R, bufPc4Next;
    logic        idValidR, idValidNext;
    logic [31:0] idInstrR, idInstrNext;
    logic [31:0] idPc4R, idPc4Next;

    logic        fire;
    logic        redir;
    logic [31:0] target;
    logic [31:0] pcPlus4;

    function automatic logic [31:0] jumpTarget(input logic [31:0] pc4, input logic [31:0] instr);
        return {pc4[31:28], instr[25:0], 2'b00};
    endfunction

    function automatic logic [31:0] branchTarget(input logic [31:0] pc4, input logic [31:0] instr);
        return pc4 + {{14{instr[15]}}, instr[15:0], 2'b00};
    endfunction

    // A transfer needs the registered request, so a stale ack right after reset is ignored.
    assign fire    = reqR & imem_ack;
    assign redir   = idValidR & ~stall & (jump | branch_taken);
    assign target  = jump ? jumpTarget(idPc4R, idInstrR) : branchTarget(idPc4R, idInstrR);
    assign pcPlus4 = pcR + 32'd4;

    // Next-state and next-register logic for the fetch FSM and IF/ID.
    always_comb begin
        stateNext    = stateR;
        pcNext       = pcR;
        redirPcNext  = redirPcR;
        bufInstrNext = bufInstrR;
        bufPc4Next   = bufPc4R;
        idValidNext  = idValidR;
        idInstrNext  = idInstrR;
        idPc4Next    = idPc4R;
        case (stateR)
            S_REQ: begin
                if (redir) begin
                    idValidNext = 1'b0;
                    idInstrNext = 32'h0000_0000;
                    if (fire) begin
                        pcNext = target;
                    end else begin
                        redirPcNext = target;
                        stateNext   = S_DROP;
                    end
                end else if (fire) begin
                    pcNext = pcPlus4;
                    if (stall) begin
                        bufInstrNext = imem_rdata;
                        bufPc4Next   = pcPlus4;
                        stateNext    = S_HOLD;
                    end else begin
                        idValidNext = 1'b1;
                        idInstrNext = imem_rdata;
                        idPc4Next   = pcPlus4;
                    end
                end else begin
                    stateNext = S_REQ;
                end
            end
            S_HOLD: begin
                if (stall) begin
                    stateNext = S_HOLD;
                end else if (redir) begin
                    pcNext      = target;
                    idValidNext = 1'b0;
                    idInstrNext = 32'h0000_0000;
                    stateNext   = S_REQ;
                end else begin
                    idValidNext = 1'b1;
                    idInstrNext = bufInstrR;
                    idPc4Next   = bufPc4R;
                    stateNext   = S_REQ;
                end
            end
            S_DROP: begin
                // The wrong-path fetch must still complete before the address may change.
                if (fire) begin
                    pcNext    = redirPcR;
                    stateNext = S_REQ;
                end else begin
                    stateNext = S_DROP;
                end
            end
            default: begin
                stateNext = S_REQ;
            end
        endcase
    end

    // State and pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateR    <= S_REQ;
            reqR      <= 1'b0;
            pcR       <= RESET_PC;
            redirPcR  <= 32'h0000_0000;
            bufInstrR <= 32'h0000_0000;
            bufPc4R   <= 32'h0000_0000;
            idValidR  <= 1'b0;
            idInstrR  <= 32'h0000_0000;
            idPc4R    <= 32'h0000_0000;
        end else begin
            stateR    <= stateNext;
            reqR      <= (stateNext != S_HOLD);
            pcR       <= pcNext;
            redirPcR  <= redirPcNext;
            bufInstrR <= bufInstrNext;
            bufPc4R   <= bufPc4Next;
            idValidR  <= idValidNext;
            idInstrR  <= idInstrNext;
            idPc4R    <= idPc4Next;
        end
    end

    assign imem_req  = reqR;
    assign imem_addr = pcR;
    assign id_valid  = idValidR;
    assign id_instr  = idInstrR;
    assign id_pc4    = idPc4R;
    assign op        = idInstrR[31:26];

endmodule

// File: tb/tb_if_stage.sv
// Directed table-driven bench for if_stage: fetch, wait states, jump/branch flush,
// S_DROP redirect, stall buffering, pc wrap and reset mid-transaction.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        jump = 1'b0;
    logic        branch_taken = 1'b0;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic [5:0]  op;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        stl;
        logic        jmp;
        logic        br;
        logic        eReq;
        logic [31:0] eAddr;
        logic        eValid;
        logic [31:0] eInstr;
        logic [31:0] ePc4;
    } vec_t;

    vec_t vecs[$];

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .jump(jump), .branch_taken(branch_taken),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc4(id_pc4), .op(op)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic ack, input logic [31:0] rdata, input logic stl,
                       input logic jmp, input logic br, input logic eReq,
                       input logic [31:0] eAddr, input logic eValid,
                       input logic [31:0] eInstr, input logic [31:0] ePc4);
        vec_t v;
        v.ack = ack; v.rdata = rdata; v.stl = stl; v.jmp = jmp; v.br = br;
        v.eReq = eReq; v.eAddr = eAddr; v.eValid = eValid; v.eInstr = eInstr; v.ePc4 = ePc4;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] instr;
        // Each row: inputs driven this cycle; expected outputs seen before this cycle's edge.
        //   ack  rdata          stl   jmp   br    req   addr           vld   instr          pc4
        add(1'b1, 32'h2400_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000);
        add(1'b1, 32'h2400_0000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000);
        add(1'b1, 32'h2400_0004, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0004, 1'b1, 32'h2400_0000, 32'h0000_0004);
        add(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0008, 1'b1, 32'h2400_0004, 32'h0000_0008);
        add(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0008, 1'b1, 32'h2400_0004, 32'h0000_0008);
        add(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0008, 1'b1, 32'h2400_0004, 32'h0000_0008);
        add(1'b1, 32'h2400_0008, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0008, 1'b1, 32'h2400_0004, 32'h0000_0008);
        add(1'b1, 32'h0800_0040, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_000C, 1'b1, 32'h2400_0008, 32'h0000_000C);
        // j 0x40 in IF/ID with branch also set: jump wins, target 0x100
        add(1'b1, 32'h2400_0010, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0010, 1'b1, 32'h0800_0040, 32'h0000_0010);
        add(1'b1, 32'h0800_0008, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 32'h0000_0000, 32'h0000_0000);
        // j 0x20 redirected while ack low: S_DROP holds 0x104 until ack
        add(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0104, 1'b1, 32'h0800_0008, 32'h0000_0104);
        add(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0104, 1'b0, 32'h0000_0000, 32'h0000_0000);
        add(1'b1, 32'hBAD0_0104, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0104, 1'b0, 32'h0000_0000, 32'h0000_0000);
        add(1'b1, 32'h1000_FFFE, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0020, 1'b0, 32'h0000_0000, 32'h0000_0000);
        // beq -2 at 0x20 taken: target 0x1C, wrong-path 0x24 discarded
        add(1'b1, 32'h2400_0024, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0024, 1'b1, 32'h1000_FFFE, 32'h0000_0024);
        add(1'b1, 32'h2400_001C, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_001C, 1'b0, 32'h0000_0000, 32'h0000_0000);
        // stall at ack for 3 cycles: instr from 0x20 buffered, req drops
        add(1'b1, 32'h1000_FFFE, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0020, 1'b1, 32'h2400_001C, 32'h0000_0020);
        add(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0024, 1'b1, 32'h2400_001C, 32'h0000_0020);
        add(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0024, 1'b1, 32'h2400_001C, 32'h0000_0020);
        add(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0024, 1'b1, 32'h2400_001C, 32'h0000_0020);
        add(1'b1, 32'h2400_0024, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0024, 1'b1, 32'h1000_FFFE, 32'h0000_0024);
        // stall at ack then redirect out of S_HOLD: buffered 0x28 dropped, jump to 0x90
        add(1'b1, 32'h2400_0028, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0028, 1'b1, 32'h2400_0024, 32'h0000_0028);
        add(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_002C, 1'b1, 32'h2400_0024, 32'h0000_0028);
        add(1'b1, 32'h1000_FFDA, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0090, 1'b0, 32'h0000_0000, 32'h0000_0000);
        // beq to 0xFFFF_FFFC, then sequential wrap to 0
        add(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0094, 1'b1, 32'h1000_FFDA, 32'h0000_0094);
        add(1'b1, 32'h2400_FFFC, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 32'h0000_0000);
        add(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 32'h2400_FFFC, 32'h0000_0000);

        imem_ack = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_instr", id_instr, 32'h0);
        chk("rst_pc4", id_pc4, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            imem_ack     = vecs[i].ack;
            imem_rdata   = vecs[i].rdata;
            stall        = vecs[i].stl;
            jump         = vecs[i].jmp;
            branch_taken = vecs[i].br;
            chk($sformatf("v%0d_req", i), {31'd0, imem_req}, {31'd0, vecs[i].eReq});
            chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].eAddr);
            chk($sformatf("v%0d_valid", i), {31'd0, id_valid}, {31'd0, vecs[i].eValid});
            chk($sformatf("v%0d_instr", i), id_instr, vecs[i].eInstr);
            instr = vecs[i].eInstr;
            chk($sformatf("v%0d_op", i), {26'd0, op}, {26'd0, instr[31:26]});
            if (vecs[i].eValid) begin
                chk($sformatf("v%0d_pc4", i), id_pc4, vecs[i].ePc4);
            end
            @(negedge clk);
        end

        // Reset mid-transaction: req falls asynchronously; a held ack is ignored after release.
        imem_ack = 1'b1;
        stall = 1'b0; jump = 1'b0; branch_taken = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_req", {31'd0, imem_req}, 32'd0);
        chk("midrst_addr", imem_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_req", {31'd0, imem_req}, 32'd1);
        chk("post_valid", {31'd0, id_valid}, 32'd0);
        chk("post_addr", imem_addr, 32'h0);
        imem_rdata = 32'h2400_0000;
        @(negedge clk);
        chk("post_valid2", {31'd0, id_valid}, 32'd1);
        chk("post_addr2", imem_addr, 32'h4);
        chk("post_instr2", id_instr, 32'h2400_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
